// File: rtl/iob_cpx_req_ctl.sv
// IO-bridge CPX requester: buffers outgoing packets and issues one-hot requests in order.
// It tracks up to two outstanding packets per core and retires them on the registered grant.
module iob_cpx_req_ctl #(
  parameter int DEPTH = 4,
  parameter int PKT_W = 145
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             pkt_vld,
  input  logic [2:0]       pkt_dest,
  input  logic [PKT_W-1:0] pkt_data,
  output logic             pkt_rdy,
  output logic [7:0]       io_cpx_req_cq,
  output logic [PKT_W-1:0] io_cpx_data_ca,
  input  logic [7:0]       cpx_io_grant_cx2,
  output logic             idle,
  output logic             grant_err
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]       dest_mem [DEPTH];
  logic [PKT_W-1:0] data_mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [1:0]       oc_reg [8];
  logic [1:0]       oc_eff [8];
  logic [7:0]       oc_nz;
  logic [7:0]       err_vec;
  logic [7:0]       issue_vec;
  logic [PKT_W-1:0] data_reg;
  logic             grant_err_reg;
  logic             empty;
  logic             full;
  logic             push;
  logic             issue;
  logic [2:0]       head_dest;
  logic [PKT_W-1:0] head_data;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pkt_rdy   = ~full & ~reset;
  assign push      = pkt_vld & pkt_rdy;
  assign head_dest = dest_mem[rd_ptr_reg[AW-1:0]];
  assign head_data = data_mem[rd_ptr_reg[AW-1:0]];

  // The credit check sees this cycle's grant, so a freed slot can be reused at once.
  assign issue     = ~reset & ~empty & (oc_eff[head_dest] != 2'd2);
  assign issue_vec = issue ? (8'b1 << head_dest) : 8'b0;

  assign io_cpx_req_cq  = issue_vec;
  assign io_cpx_data_ca = data_reg;
  assign grant_err      = grant_err_reg;
  assign idle           = empty & ~(|oc_nz);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_core
      assign oc_nz[gi]   = (oc_reg[gi] != 2'd0);
      assign oc_eff[gi]  = (cpx_io_grant_cx2[gi] && oc_nz[gi]) ? oc_reg[gi] - 2'd1 : oc_reg[gi];
      assign err_vec[gi] = cpx_io_grant_cx2[gi] & ~issue_vec[gi] & ~oc_nz[gi];

      always_ff @(posedge rclk) begin
        if (reset) begin
          oc_reg[gi] <= 2'd0;
        end else begin
          case ({issue_vec[gi], cpx_io_grant_cx2[gi]})
            2'b10:   oc_reg[gi] <= oc_reg[gi] + 2'd1;
            2'b01:   oc_reg[gi] <= oc_nz[gi] ? oc_reg[gi] - 2'd1 : 2'd0;
            default: oc_reg[gi] <= oc_reg[gi];
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge rclk) begin
    if (push) begin
      dest_mem[wr_ptr_reg[AW-1:0]] <= pkt_dest;
      data_mem[wr_ptr_reg[AW-1:0]] <= pkt_data;
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      data_reg      <= '0;
      grant_err_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (issue)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // Data follows its request by one cycle and is zero otherwise.
      data_reg      <= issue ? head_data : '0;
      grant_err_reg <= grant_err_reg | (|err_vec);
    end
  end

endmodule
